// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state and op encodings for the ALU operand path
package alu_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        SHOW    = 2'b11
    } ld_state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

endpackage

// File: rtl/btn_rise_sync.sv
// rtl/btn_rise_sync.sv - button synchronizer with registered rising-edge pulse
module btn_rise_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    logic [SYNC_STG-1:0] sync;
    logic                prev;

    // pulse is registered so a held button gives exactly one cycle, re-arming once prev sees low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STG-2:0], raw};
            prev  <= sync[SYNC_STG-1];
            pulse <= sync[SYNC_STG-1] & ~prev;
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - steps operand A, operand B and op select in from switches
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int N        = 16,
    parameter int SYNC_STG = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_data_i,
    input  logic [1:0]   sw_op_i,
    input  logic         btn_next_i,
    input  logic         btn_clr_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [1:0]   op_o,
    output logic         valid_o,
    output logic [1:0]   state_o
);

    ld_state_t state;
    ld_state_t next_state;
    logic      nxt;

    btn_rise_sync #(.SYNC_STG(SYNC_STG)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_next_i),
        .pulse (nxt)
    );

    always_comb begin
        next_state = state;
        case (state)
            LOAD_A:  next_state = LOAD_B;
            LOAD_B:  next_state = LOAD_OP;
            LOAD_OP: next_state = SHOW;
            SHOW:    next_state = LOAD_A;
            default: next_state = LOAD_A;
        endcase
    end

    // clear takes priority and swallows a coincident nxt pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD_A;
            a_o     <= '0;
            b_o     <= '0;
            op_o    <= OP_ADD;
            valid_o <= 1'b0;
        end else if (btn_clr_i) begin
            state   <= LOAD_A;
            a_o     <= '0;
            b_o     <= '0;
            op_o    <= OP_ADD;
            valid_o <= 1'b0;
        end else if (nxt) begin
            state   <= next_state;
            valid_o <= (next_state == SHOW);
            case (state)
                LOAD_A:  a_o  <= sw_data_i;
                LOAD_B:  b_o  <= sw_data_i;
                LOAD_OP: op_o <= sw_op_i;
                default: ;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed self-checking bench for alu_operand_loader
module tb_alu_operand_loader;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw_data = '0;
    logic [1:0]  sw_op = '0;
    logic        btn_next = 1'b0;
    logic        btn_clr = 1'b0;
    logic [15:0] a, b;
    logic [1:0]  op, state;
    logic        valid;

    int checks = 0;
    int failures = 0;

    alu_operand_loader #(.N(16), .SYNC_STG(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_data_i  (sw_data),
        .sw_op_i    (sw_op),
        .btn_next_i (btn_next),
        .btn_clr_i  (btn_clr),
        .a_o        (a),
        .b_o        (b),
        .op_o       (op),
        .valid_o    (valid),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  opsel;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [1:0]  exp_op;
        logic [1:0]  exp_state;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                             input logic [1:0] eo, input logic [1:0] es, input logic ev);
        check({tag, "_a"}, 32'(a), 32'(ea));
        check({tag, "_b"}, 32'(b), 32'(eb));
        check({tag, "_op"}, 32'(op), 32'(eo));
        check({tag, "_state"}, 32'(state), 32'(es));
        check({tag, "_valid"}, 32'(valid), 32'(ev));
    endtask

    // one-cycle press; checks the state has not moved yet just before the third edge
    task automatic press(input logic [15:0] d, input logic [1:0] o, input logic [1:0] pre_state);
        @(negedge clk); sw_data = d; sw_op = o; btn_next = 1'b1;
        @(negedge clk); btn_next = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("latency_hold_state", 32'(state), 32'(pre_state));
        @(negedge clk);
    endtask

    task automatic toggle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sw_data = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
            sw_op   = (i % 2 == 0) ? 2'b10 : 2'b01;
        end
    endtask

    initial begin
        logic [1:0] prev_state;

        vecs[0] = '{16'h1234, 2'b00, 16'h1234, 16'h0000, OP_ADD, 2'b01, 1'b0};
        vecs[1] = '{16'h0F0F, 2'b00, 16'h1234, 16'h0F0F, OP_ADD, 2'b10, 1'b0};
        vecs[2] = '{16'h0000, OP_SUB, 16'h1234, 16'h0F0F, OP_SUB, 2'b11, 1'b1};
        vecs[3] = '{16'h0000, 2'b11, 16'h1234, 16'h0F0F, OP_SUB, 2'b00, 1'b0};
        vecs[4] = '{16'hFFFF, 2'b11, 16'hFFFF, 16'h0F0F, OP_SUB, 2'b01, 1'b0};

        repeat (3) @(negedge clk);
        check_all("reset", 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // full entry, wrap, and overwrite of A; switches toggle between presses
        prev_state = 2'b00;
        for (int i = 0; i < 5; i++) begin
            press(vecs[i].data, vecs[i].opsel, prev_state);
            toggle_gap(6);
            check_all($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b,
                      vecs[i].exp_op, vecs[i].exp_state, vecs[i].exp_valid);
            prev_state = vecs[i].exp_state;
        end

        @(negedge clk); btn_clr = 1'b1;
        @(negedge clk); btn_clr = 1'b0;
        check_all("clear", 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);

        // held button for 50 cycles captures only A
        @(negedge clk); sw_data = 16'h1111; btn_next = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i >= 4) sw_data = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
        end
        btn_next = 1'b0;
        repeat (5) @(negedge clk);
        check_all("held", 16'h1111, 16'h0, 2'b00, 2'b01, 1'b0);

        // clear coincides with the nxt pulse in LOAD_B
        @(negedge clk); sw_data = 16'h2222; btn_next = 1'b1;
        @(negedge clk); btn_next = 1'b0;
        @(negedge clk);
        @(negedge clk); btn_clr = 1'b1;
        @(negedge clk); btn_clr = 1'b0;
        check_all("clr_vs_nxt", 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
        repeat (5) @(negedge clk);
        check("clr_not_deferred_state", 32'(state), 32'h0);

        // asynchronous reset mid-sequence
        press(16'hBEEF, 2'b00, 2'b00);
        check("pre_reset_a", 32'(a), 32'h0000BEEF);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_all("async_reset", 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all("after_reset", 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
